// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: per-source skid FIFOs feeding a round-robin grant onto
// a registered CDB. Sources are ALU (index 0) and LSB (index 1).

module cdb_skid_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full
);
    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    do_pop, do_push;

    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    assign head  = mem_q[head_q];

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != '0);
        // A full FIFO still accepts a push when its head leaves on the same edge.
        do_push = push && (!full || do_pop);
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = din;
                tail_d        = tail_q + PW'(1);
            end
            if (do_pop)
                head_d = head_q + PW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else if (en) begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en)
            mem_q <= mem_d;
    end
endmodule

module cdb_arbiter #(
    parameter int ROB_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic [31:0]      alu_value,
    output logic             alu_stall,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_value,
    output logic             lsb_stall,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic [31:0]      cdb_value,
    output logic             cdb_src,
    output logic             err_overflow
);
    localparam int DW = ROB_W + 32;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]          in_valid, has_fifo, cand, took, push, pop, full, ovf;
    logic [1:0][DW-1:0]  in_data, head, cand_data;
    logic [1:0][CW-1:0]  cnt;
    logic                any_grant, win;

    logic             cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [31:0]      cdb_value_q, cdb_value_d;
    logic             cdb_src_q, cdb_src_d;
    logic             rr_last_q, rr_last_d;
    logic             err_q, err_d;

    assign in_valid = {lsb_valid, alu_valid};
    assign in_data  = {{lsb_rob_id, lsb_value}, {alu_rob_id, alu_value}};

    for (genvar s = 0; s < 2; s++) begin : g_src
        cdb_skid_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .en    (rdy),
            .flush (clear),
            .push  (push[s]),
            .pop   (pop[s]),
            .din   (in_data[s]),
            .head  (head[s]),
            .count (cnt[s]),
            .full  (full[s])
        );
    end

    assign alu_stall = (cnt[0] >= CW'(DEPTH - 1));
    assign lsb_stall = (cnt[1] >= CW'(DEPTH - 1));

    // Candidate is the FIFO head if queued, otherwise the live input (bypass).
    always_comb begin
        has_fifo  = '0;
        cand      = '0;
        cand_data = '0;
        took      = '0;
        push      = '0;
        pop       = '0;
        ovf       = '0;
        for (int s = 0; s < 2; s++) begin
            has_fifo[s]  = (cnt[s] != '0);
            cand[s]      = has_fifo[s] | in_valid[s];
            cand_data[s] = has_fifo[s] ? head[s] : in_data[s];
        end
        any_grant = |cand;
        win       = (&cand) ? ~rr_last_q : cand[1];
        for (int s = 0; s < 2; s++) begin
            took[s] = any_grant && (win == s[0]);
            pop[s]  = took[s] && has_fifo[s];
            push[s] = in_valid[s] && !(took[s] && !has_fifo[s]);
            ovf[s]  = push[s] && full[s] && !pop[s];
        end
    end

    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_value_d  = cdb_value_q;
        cdb_src_d    = cdb_src_q;
        rr_last_d    = rr_last_q;
        err_d        = err_q;
        if (clear) begin
            cdb_valid_d  = 1'b0;
            cdb_rob_id_d = '0;
            cdb_value_d  = '0;
            cdb_src_d    = 1'b0;
        end else begin
            cdb_valid_d = any_grant;
            if (any_grant) begin
                {cdb_rob_id_d, cdb_value_d} = cand_data[win];
                cdb_src_d = win;
                rr_last_d = win;
            end
            err_d = err_q | (|ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= 1'b0;
            rr_last_q    <= 1'b1;
            err_q        <= 1'b0;
        end else if (rdy) begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_value_q  <= cdb_value_d;
            cdb_src_q    <= cdb_src_d;
            rr_last_q    <= rr_last_d;
            err_q        <= err_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_rob_id   = cdb_rob_id_q;
    assign cdb_value    = cdb_value_q;
    assign cdb_src      = cdb_src_q;
    assign err_overflow = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: fixed vector table, hand sequences for overflow,
// flush and freeze, then random traffic against a queue-based model.

module tb_cdb_arbiter;
    localparam int ROB_W = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst, rdy, clear;
    logic             alu_valid, lsb_valid;
    logic [ROB_W-1:0] alu_rob_id, lsb_rob_id;
    logic [31:0]      alu_value, lsb_value;
    logic             alu_stall, lsb_stall;
    logic             cdb_valid, cdb_src, err_overflow;
    logic [ROB_W-1:0] cdb_rob_id;
    logic [31:0]      cdb_value;

    cdb_arbiter #(.ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value), .alu_stall(alu_stall),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value), .lsb_stall(lsb_stall),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value), .cdb_src(cdb_src),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ROB_W-1:0] tag;
        logic [31:0]      val;
    } ent_t;

    // Reference model: one pending queue per source plus the broadcast state.
    ent_t             aq[$], lq[$];
    logic             m_v, m_src, m_err, m_rr;
    logic [ROB_W-1:0] m_tag;
    logic [31:0]      m_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic rd, input logic cl,
                              input logic av, input ent_t ae, input logic lv, input ent_t le);
        ent_t ta[$];
        ent_t tl[$];
        ent_t e;
        logic w;
        if (r) begin
            aq.delete(); lq.delete();
            m_v = 0; m_tag = 0; m_val = 0; m_src = 0; m_err = 0; m_rr = 1;
        end else if (!rd) begin
            // frozen
        end else if (cl) begin
            aq.delete(); lq.delete();
            m_v = 0; m_tag = 0; m_val = 0; m_src = 0;
        end else begin
            ta = aq; tl = lq;
            if (av) ta.push_back(ae);
            if (lv) tl.push_back(le);
            if (ta.size() > 0 || tl.size() > 0) begin
                if (ta.size() > 0 && tl.size() > 0) w = ~m_rr;
                else w = (tl.size() > 0);
                e = w ? tl.pop_front() : ta.pop_front();
                m_v = 1; m_tag = e.tag; m_val = e.val; m_src = w; m_rr = w;
            end else begin
                m_v = 0;
            end
            if (ta.size() > DEPTH) begin void'(ta.pop_back()); m_err = 1; end
            if (tl.size() > DEPTH) begin void'(tl.pop_back()); m_err = 1; end
            aq = ta; lq = tl;
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic cl,
                        input logic av, input logic [ROB_W-1:0] at, input logic [31:0] avl,
                        input logic lv, input logic [ROB_W-1:0] lt, input logic [31:0] lvl);
        rst = r; rdy = rd; clear = cl;
        alu_valid = av; alu_rob_id = at; alu_value = avl;
        lsb_valid = lv; lsb_rob_id = lt; lsb_value = lvl;
        model_edge(r, rd, cl, av, {at, avl}, lv, {lt, lvl});
        @(posedge clk);
        #1;
        chk("cdb_valid", 32'(cdb_valid), 32'(m_v));
        chk("cdb_rob_id", 32'(cdb_rob_id), 32'(m_tag));
        chk("cdb_value", cdb_value, m_val);
        chk("cdb_src", 32'(cdb_src), 32'(m_src));
        chk("alu_stall", 32'(alu_stall), 32'(aq.size() >= DEPTH - 1));
        chk("lsb_stall", 32'(lsb_stall), 32'(lq.size() >= DEPTH - 1));
        chk("err_overflow", 32'(err_overflow), 32'(m_err));
    endtask

    task automatic idle(); step(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic both(input int k);
        step(0, 1, 0, 1, ROB_W'(k), 32'h100 + k, 1, ROB_W'(8 + k), 32'h200 + k);
    endtask

    typedef struct {
        logic             r, av, lv;
        logic [ROB_W-1:0] at, lt;
        logic [31:0]      avl, lvl;
        logic             ev, es, eas, els;
        logic [ROB_W-1:0] et;
        logic [31:0]      evl;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic av, input int at, input int avl,
                                input logic lv, input int lt, input int lvl,
                                input logic ev, input int et, input int evl, input logic es,
                                input logic eas, input logic els);
        vec_t v;
        v.r = r; v.av = av; v.at = ROB_W'(at); v.avl = 32'(avl);
        v.lv = lv; v.lt = ROB_W'(lt); v.lvl = 32'(lvl);
        v.ev = ev; v.et = ROB_W'(et); v.evl = 32'(evl); v.es = es; v.eas = eas; v.els = els;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // reset, single ALU result, then simultaneous ALU/LSB after reset
        tbl.push_back(mk(1, 0,0,0,      0,0,0,      0, 0,'h0,   0, 0,0));
        tbl.push_back(mk(0, 1,3,'h11,   0,0,0,      1, 3,'h11,  0, 0,0));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0, 3,'h11,  0, 0,0));
        tbl.push_back(mk(1, 0,0,0,      0,0,0,      0, 0,'h0,   0, 0,0));
        tbl.push_back(mk(0, 1,1,'hA1,   1,2,'hB2,   1, 1,'hA1,  0, 0,0));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      1, 2,'hB2,  1, 0,0));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0, 2,'hB2,  1, 0,0));
        // six cycles of both sources, then drain: strict alternation
        tbl.push_back(mk(0, 1,0,'h100,  1,8,'h200,  1, 0,'h100, 0, 0,0));
        tbl.push_back(mk(0, 1,1,'h101,  1,9,'h201,  1, 8,'h200, 1, 0,0));
        tbl.push_back(mk(0, 1,2,'h102,  1,10,'h202, 1, 1,'h101, 0, 0,0));
        tbl.push_back(mk(0, 1,3,'h103,  1,11,'h203, 1, 9,'h201, 1, 0,0));
        tbl.push_back(mk(0, 1,4,'h104,  1,12,'h204, 1, 2,'h102, 0, 0,1));
        tbl.push_back(mk(0, 1,5,'h105,  1,13,'h205, 1, 10,'h202,1, 1,1));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      1, 3,'h103, 0, 0,1));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      1, 11,'h203,1, 0,0));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      1, 4,'h104, 0, 0,0));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      1, 12,'h204,1, 0,0));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      1, 5,'h105, 0, 0,0));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      1, 13,'h205,1, 0,0));
        tbl.push_back(mk(0, 0,0,0,      0,0,0,      0, 13,'h205,1, 0,0));

        foreach (tbl[i]) begin
            step(tbl[i].r, 1, 0, tbl[i].av, tbl[i].at, tbl[i].avl, tbl[i].lv, tbl[i].lt, tbl[i].lvl);
            chk($sformatf("tbl%0d_valid", i), 32'(cdb_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_tag", i), 32'(cdb_rob_id), 32'(tbl[i].et));
            chk($sformatf("tbl%0d_value", i), cdb_value, tbl[i].evl);
            chk($sformatf("tbl%0d_src", i), 32'(cdb_src), 32'(tbl[i].es));
            chk($sformatf("tbl%0d_astall", i), 32'(alu_stall), 32'(tbl[i].eas));
            chk($sformatf("tbl%0d_lstall", i), 32'(lsb_stall), 32'(tbl[i].els));
            chk($sformatf("tbl%0d_err", i), 32'(err_overflow), 0);
        end

        // overflow: fill both FIFOs, then push ALU while LSB owns the grant
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) both(k);
        chk("ovf_full_stall", 32'(alu_stall), 1);
        step(0, 1, 0, 1, 4'd8, 32'h108, 0, 0, 0);
        chk("ovf_popfull_noerr", 32'(err_overflow), 0);
        step(0, 1, 0, 1, 4'd9, 32'h109, 0, 0, 0);
        chk("ovf_err_set", 32'(err_overflow), 1);
        for (int k = 0; k < 10; k++) idle();
        chk("ovf_err_sticky", 32'(err_overflow), 1);

        // clear with queued results: nothing from before the flush ever appears
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) both(k);
        step(0, 1, 1, 1, 4'd7, 32'h77, 1, 4'd15, 32'hFF);
        chk("clr_valid", 32'(cdb_valid), 0);
        chk("clr_tag", 32'(cdb_rob_id), 0);
        chk("clr_astall", 32'(alu_stall), 0);
        chk("clr_lstall", 32'(lsb_stall), 0);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("clr_after_valid", 32'(cdb_valid), 0);
        end

        // freeze: three cycles of rdy=0 with live inputs change nothing
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) both(k);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 4'd6, 32'h66, 1, 4'd14, 32'hEE);
            chk("frz_valid", 32'(cdb_valid), 1);
            chk("frz_tag", 32'(cdb_rob_id), 1);
            chk("frz_value", cdb_value, 32'h101);
        end
        idle();
        chk("frz_resume_tag", 32'(cdb_rob_id), 9);
        chk("frz_resume_src", 32'(cdb_src), 1);
        for (int k = 0; k < 8; k++) idle();

        // random traffic; stalls mostly honoured so overflow is rare but reachable
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 800; n++) begin
            logic r, rd, cl, av, lv;
            r  = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 39) == 0);
            av = alu_stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            lv = lsb_stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            step(r, rd, cl, av, ROB_W'($urandom), $urandom, lv, ROB_W'($urandom), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
